// File: rtl/wide_adder_sequencer_pkg.sv
// rtl/wide_adder_sequencer_pkg.sv - shared constants and FSM encoding for the chunked wide adder
package wide_adder_sequencer_pkg;

    localparam int CHUNK_W  = 16;
    localparam int CHUNK_LG = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wide_adder_sequencer_if.sv
// rtl/wide_adder_sequencer_if.sv - operand/result handshake bundle for the wide adder sequencer
interface wide_adder_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/wide_adder_sequencer_cla.sv
// rtl/wide_adder_sequencer_cla.sv - 16-bit carry-lookahead adder (four 4-bit groups, lookahead across groups)
module carry_lookahead_adder_16b (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_c,
    output logic [15:0] o_sum,
    output logic        o_c
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_pg;
    logic [4:0]  w_cg;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_gg = '0;
        w_pg = '0;
        w_cg = '0;
        w_c  = '0;
        for (int j = 0; j < 4; j++) begin
            w_pg[j] = &w_p[4*j +: 4];
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
        end
        w_cg[0] = i_c;
        for (int j = 0; j < 4; j++) begin
            w_cg[j+1] = w_gg[j] | (w_pg[j] & w_cg[j]);
        end
        for (int j = 0; j < 4; j++) begin
            w_c[4*j] = w_cg[j];
        end
        // Carries inside a group ripple from that group's lookahead carry-in.
        for (int i = 1; i < 16; i++) begin
            if ((i % 4) != 0) begin
                w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
            end
        end
    end

    assign o_sum = w_p ^ w_c;
    assign o_c   = w_cg[4];
endmodule

// File: rtl/wide_adder_sequencer.sv
// rtl/wide_adder_sequencer.sv - multi-cycle WIDTH-bit adder, one 16-bit chunk per cycle, LSB first
// Optional subtract support is built when WAS_SUBTRACT_EN is defined.
module wide_adder_sequencer
    import wide_adder_sequencer_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 clr,
    wide_adder_sequencer_if.slave bus
);
    localparam int N  = WIDTH / CHUNK_W;
    localparam int KW = cnt_width(N);

    if ((WIDTH < CHUNK_W) || ((WIDTH % CHUNK_W) != 0)) begin : g_width_check
        $error("wide_adder_sequencer: WIDTH must be a multiple of 16 and >= 16");
    end

    state_t             r_state;
    logic [KW-1:0]      r_k;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [KW+CHUNK_LG-1:0] w_base;
    logic [CHUNK_W-1:0]     w_a_chunk;
    logic [CHUNK_W-1:0]     w_b_chunk;
    logic [CHUNK_W-1:0]     w_cla_sum;
    logic                   w_cla_c;
    logic                   w_sub_in;
    logic                   w_sub_eff;

    assign w_base    = {r_k, {CHUNK_LG{1'b0}}};
    assign w_a_chunk = r_a[w_base +: CHUNK_W];

`ifdef WAS_SUBTRACT_EN
    logic r_sub;

    assign w_sub_in  = bus.sub;
    assign w_sub_eff = r_sub;
    assign w_b_chunk = r_b[w_base +: CHUNK_W] ^ {CHUNK_W{r_sub}};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sub <= 1'b0;
        end else if ((r_state == ST_IDLE) && bus.in_valid) begin
            r_sub <= bus.sub;
        end
    end
`else
    logic w_unused_sub;

    assign w_unused_sub = bus.sub;
    assign w_sub_in     = 1'b0;
    assign w_sub_eff    = 1'b0;
    assign w_b_chunk    = r_b[w_base +: CHUNK_W];
`endif

    carry_lookahead_adder_16b _cla (
        .i_a   (w_a_chunk),
        .i_b   (w_b_chunk),
        .i_c   (r_carry),
        .o_sum (w_cla_sum),
        .o_c   (w_cla_c)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= w_sub_in ? 1'b1 : bus.c_in;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: CHUNK_W] <= w_cla_sum;
                    r_carry                  <= w_cla_c;
                    r_k                      <= r_k + 1'b1;
                    if (r_k == KW'(N - 1)) begin
                        r_c_out     <= w_cla_c;
                        r_ovf       <= (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ w_sub_eff))
                                     & (w_cla_sum[CHUNK_W-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result is held until consumed; the next accept waits for IDLE.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_wide_adder_sequencer.sv
// tb/tb_wide_adder_sequencer.sv - randomized self-checking bench for wide_adder_sequencer at WIDTH=64 and WIDTH=16
module tb_wide_adder_sequencer;

`ifdef WAS_SUBTRACT_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wide_adder_sequencer_if #(.WIDTH(64)) i64 ();
    wide_adder_sequencer_if #(.WIDTH(16)) i16 ();

    wide_adder_sequencer #(.WIDTH(64)) dut64 (.clk(clk), .clr(clr), .bus(i64));
    wide_adder_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .clr(clr), .bus(i16));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic signed [65:0] sx(input logic [63:0] v, input int w);
        logic signed [65:0] r;
        r = $signed({2'b00, v});
        if (v[w-1]) r = r - (66'sd1 <<< w);
        return r;
    endfunction

    // Reference: plain integer add/subtract at width w, signed overflow by range check.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, output logic [63:0] s, output logic co, output logic ov);
        logic [63:0]        mask;
        logic [63:0]        am;
        logic [63:0]        bm;
        logic [64:0]        full;
        logic signed [65:0] r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        if (sub) begin
            full = {1'b0, am} - {1'b0, bm};
            co   = (am >= bm);
            r    = sx(am, w) - sx(bm, w);
        end else begin
            full = {1'b0, am} + {1'b0, bm} + 65'(cin);
            co   = full[w];
            r    = sx(am, w) + sx(bm, w) + 66'(cin);
        end
        s  = full[63:0] & mask;
        ov = (r > ((66'sd1 <<< (w - 1)) - 66'sd1)) || (r < -(66'sd1 <<< (w - 1)));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 12 && !(i64.in_ready && i16.in_ready); i++) @(negedge clk);
    endtask

    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, output logic [63:0] s64, output logic co64, output logic ov64);
        logic [63:0] es;
        logic [63:0] es16;
        logic        ec, eo, ec16, eo16;
        int          lat64;
        int          lat16;
        model(64, a, b, cin, sub & SUB_EN, es, ec, eo);
        model(16, a, b, cin, sub & SUB_EN, es16, ec16, eo16);
        lat64 = -1;
        lat16 = -1;
        s64 = 'x; co64 = 1'bx; ov64 = 1'bx;
        wait_idle();
        check({tag, ".in_ready"}, {62'd0, i64.in_ready, i16.in_ready}, 64'd3);
        i64.a = a;       i64.b = b;       i64.c_in = cin; i64.sub = sub; i64.in_valid = 1'b1;
        i16.a = a[15:0]; i16.b = b[15:0]; i16.c_in = cin; i16.sub = sub; i16.in_valid = 1'b1;
        @(negedge clk);
        i64.in_valid = 1'b0;
        i16.in_valid = 1'b0;
        for (int cyc = 1; cyc <= 10 && (lat64 < 0 || lat16 < 0); cyc++) begin
            @(negedge clk);
            if (lat16 < 0 && i16.out_valid) begin
                lat16 = cyc;
                check({tag, ".sum16"}, 64'(i16.sum), es16);
                check({tag, ".cout16"}, 64'(i16.c_out), 64'(ec16));
                check({tag, ".ovf16"}, 64'(i16.ovf), 64'(eo16));
            end
            if (lat64 < 0 && i64.out_valid) begin
                lat64 = cyc;
                s64 = i64.sum; co64 = i64.c_out; ov64 = i64.ovf;
                check({tag, ".sum64"}, i64.sum, es);
                check({tag, ".cout64"}, 64'(i64.c_out), 64'(ec));
                check({tag, ".ovf64"}, 64'(i64.ovf), 64'(eo));
            end
        end
        check({tag, ".lat64"}, 64'(lat64), 64'd4);
        check({tag, ".lat16"}, 64'(lat16), 64'd1);
    endtask

    initial begin
        logic [63:0] s;
        logic        co, ov;
        int          seen;
        clr = 1'b1;
        i64.in_valid = 1'b0; i64.a = '0; i64.b = '0; i64.c_in = 1'b0; i64.sub = 1'b0; i64.out_ready = 1'b1;
        i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.c_in = 1'b0; i16.sub = 1'b0; i16.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("rst.in_ready", 64'(i64.in_ready), 64'd1);
        check("rst.out_valid", 64'(i64.out_valid), 64'd0);
        check("rst.sum", i64.sum, 64'd0);
        check("rst.c_out", 64'(i64.c_out), 64'd0);
        check("rst.ovf", 64'(i64.ovf), 64'd0);
        check("rst.in_ready16", 64'(i16.in_ready), 64'd1);

        do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, s, co, ov);
        check("ripple.sum", s, 64'd0);
        check("ripple.cout", 64'(co), 64'd1);
        check("ripple.ovf", 64'(ov), 64'd0);

        do_op("chunk", 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0, s, co, ov);
        check("chunk.sum", s, 64'h0000_0001_0000_0000);
        check("chunk.cout", 64'(co), 64'd0);

        do_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, s, co, ov);
        check("sovf.ovf", 64'(ov), 64'd1);

        do_op("sub", 64'd5, 64'd7, 1'b0, 1'b1, s, co, ov);
`ifdef WAS_SUBTRACT_EN
        check("sub.sum", s, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub.cout", 64'(co), 64'd0);
`else
        check("sub.sum", s, 64'd12);
        check("sub.cout", 64'(co), 64'd0);
`endif

        // Backpressure: result must hold while in_valid keeps offering a new op.
        wait_idle();
        i64.out_ready = 1'b0;
        i64.a = 64'h1234; i64.b = 64'd1; i64.c_in = 1'b0; i64.sub = 1'b0; i64.in_valid = 1'b1;
        @(negedge clk);
        i64.a = 64'h0123_4567_89AB_CDEF; i64.b = 64'h1111_1111_1111_1111;
        for (int i = 0; i < 10 && !i64.out_valid; i++) @(negedge clk);
        check("bp.valid", 64'(i64.out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.hold_valid", 64'(i64.out_valid), 64'd1);
            check("bp.hold_ready", 64'(i64.in_ready), 64'd0);
            check("bp.hold_sum", i64.sum, 64'h1235);
        end
        i64.out_ready = 1'b1;
        @(negedge clk);
        check("bp.rel_valid", 64'(i64.out_valid), 64'd0);
        check("bp.rel_ready", 64'(i64.in_ready), 64'd1);
        @(negedge clk);
        check("bp.next_accept", 64'(i64.in_ready), 64'd0);
        i64.in_valid = 1'b0;
        for (int i = 0; i < 10 && !i64.out_valid; i++) @(negedge clk);
        check("bp.next_valid", 64'(i64.out_valid), 64'd1);
        check("bp.next_sum", i64.sum, 64'h1234_5678_9ABC_DF00);

        // Asynchronous clear mid-cycle while a result is held.
        wait_idle();
        i64.out_ready = 1'b0;
        i64.a = 64'd3; i64.b = 64'd4; i64.in_valid = 1'b1;
        @(negedge clk);
        i64.in_valid = 1'b0;
        for (int i = 0; i < 10 && !i64.out_valid; i++) @(negedge clk);
        check("arst.pre_sum", i64.sum, 64'd7);
        #2 clr = 1'b1;
        #1;
        check("arst.out_valid", 64'(i64.out_valid), 64'd0);
        check("arst.sum", i64.sum, 64'd0);
        check("arst.in_ready", 64'(i64.in_ready), 64'd1);
        clr = 1'b0;
        i64.out_ready = 1'b1;

        // Clear while k==2: the operation must vanish without output.
        wait_idle();
        i64.a = 64'hFFFF_0000_FFFF_0000; i64.b = 64'h0001_0001_0001_0001; i64.in_valid = 1'b1;
        @(negedge clk);
        i64.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 clr = 1'b1;
        #1;
        check("rstrun.in_ready", 64'(i64.in_ready), 64'd1);
        clr = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (i64.out_valid) seen++;
        end
        check("rstrun.no_out", 64'(seen), 64'd0);

        for (int n = 0; n < 1000; n++) begin
            logic [63:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? {64{1'b1}} : {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            do_op("soak", ra, rb, 1'($urandom), 1'($urandom), s, co, ov);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
